// File: rtl/fp16_pkg.sv
// Shared fp16 definitions for the multiplier back end: field widths, packed
// result type and the normalize/round controller states.
package fp16_pkg;

  localparam int unsigned FP_EXP_W   = 4;
  localparam int unsigned FP_FRAC_W  = 11;
  localparam int          FP_BIAS    = 7;
  localparam int          FP_EXP_MAX = 15;

  typedef struct packed {
    logic                 sign;
    logic [FP_EXP_W-1:0]  exp;
    logic [FP_FRAC_W-1:0] frac;
  } fp16_t;

  typedef enum logic [1:0] {
    StIdle,
    StNorm,
    StRound,
    StDone
  } state_e;

endpackage

// File: rtl/fp_round.sv
// Combinational rounding, carry renormalization and exponent range check.
// Optional macro FP_NORM_RNE_EN: defined selects round-to-nearest-even,
// undefined selects truncation.
module fp_round import fp16_pkg::*; #(
  parameter int unsigned EXP_W = 7
) (
  input  logic                    sign_i,
  input  logic signed [EXP_W-1:0] exp_i,
  input  logic [FP_FRAC_W-1:0]    frac_i,
  input  logic                    guard_i,
  input  logic                    sticky_i,
  input  logic                    zero_i,
  output fp16_t                   result_o,
  output logic                    ovf_o,
  output logic                    unf_o
);

  localparam logic signed [EXP_W-1:0] ExpZero = '0;
  localparam logic signed [EXP_W-1:0] ExpMax  = EXP_W'(FP_EXP_MAX);

  logic inc;

`ifdef FP_NORM_RNE_EN
  assign inc = guard_i & (sticky_i | frac_i[0]);
`else
  // Truncation drops the round bits entirely.
  logic unused_round_bits;
  assign unused_round_bits = guard_i ^ sticky_i;
  assign inc = 1'b0;
`endif

  logic [FP_FRAC_W:0]      frac_sum;
  logic [FP_FRAC_W-1:0]    frac_rnd;
  logic signed [EXP_W-1:0] exp_rnd;

  // Round, renormalize on fraction carry-out, then saturate or flush.
  always_comb begin
    frac_sum = {1'b0, frac_i} + {{FP_FRAC_W{1'b0}}, inc};
    frac_rnd = frac_sum[FP_FRAC_W-1:0];
    exp_rnd  = exp_i;
    if (frac_sum[FP_FRAC_W]) begin
      frac_rnd = '0;
      exp_rnd  = exp_i + EXP_W'(1);
    end

    result_o.sign = sign_i;
    result_o.exp  = '0;
    result_o.frac = '0;
    ovf_o         = 1'b0;
    unf_o         = 1'b0;
    if (zero_i || (exp_rnd <= ExpZero)) begin
      unf_o = 1'b1;
    end else if (exp_rnd > ExpMax) begin
      result_o.exp  = '1;
      result_o.frac = '1;
      ovf_o         = 1'b1;
    end else begin
      result_o.exp  = exp_rnd[FP_EXP_W-1:0];
      result_o.frac = frac_rnd;
    end
  end

endmodule

// File: rtl/fp_norm_round.sv
// Normalize-and-round stage for the fp16 multiplier product. A shift FSM
// brings the leading one to bit SIG_W-2, then fp_round produces the packed
// result. Rounding mode is selected by FP_NORM_RNE_EN inside fp_round.
module fp_norm_round import fp16_pkg::*; #(
  parameter int unsigned EXP_W = 7,
  parameter int unsigned SIG_W = 24
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    in_sign,
  input  logic signed [EXP_W-1:0] in_exp,
  input  logic [SIG_W-1:0]        in_sig,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [15:0]             out_result,
  output logic                    out_ovf,
  output logic                    out_unf
);

  // Binary point sits between SIG_W-2 and SIG_W-3; fraction follows it.
  localparam int unsigned FracMsb  = SIG_W - 3;
  localparam int unsigned GuardBit = SIG_W - 3 - FP_FRAC_W;

  state_e                  state_q, state_d;
  logic                    sign_q, sign_d;
  logic signed [EXP_W-1:0] exp_q, exp_d;
  logic [SIG_W-1:0]        sig_q, sig_d;
  logic                    sticky_q, sticky_d;
  logic                    zero_q, zero_d;
  fp16_t                   result_q, result_d;
  logic                    ovf_q, ovf_d;
  logic                    unf_q, unf_d;

  fp16_t rnd_result;
  logic  rnd_ovf;
  logic  rnd_unf;

  fp_round #(
    .EXP_W(EXP_W)
  ) u_fp_round (
    .sign_i   (sign_q),
    .exp_i    (exp_q),
    .frac_i   (sig_q[FracMsb -: FP_FRAC_W]),
    .guard_i  (sig_q[GuardBit]),
    .sticky_i (sticky_q | (|sig_q[GuardBit-1:0])),
    .zero_i   (zero_q),
    .result_o (rnd_result),
    .ovf_o    (rnd_ovf),
    .unf_o    (rnd_unf)
  );

  // Next-state: capture, one normalization step per cycle, latch result.
  always_comb begin
    state_d  = state_q;
    sign_d   = sign_q;
    exp_d    = exp_q;
    sig_d    = sig_q;
    sticky_d = sticky_q;
    zero_d   = zero_q;
    result_d = result_q;
    ovf_d    = ovf_q;
    unf_d    = unf_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          sign_d   = in_sign;
          exp_d    = in_exp;
          sig_d    = in_sig;
          sticky_d = 1'b0;
          zero_d   = 1'b0;
          state_d  = StNorm;
        end
      end
      StNorm: begin
        if (sig_q == '0) begin
          zero_d  = 1'b1;
          state_d = StRound;
        end else if (sig_q[SIG_W-1]) begin
          sig_d    = sig_q >> 1;
          sticky_d = sticky_q | sig_q[0];
          exp_d    = exp_q + EXP_W'(1);
          state_d  = StRound;
        end else if (sig_q[SIG_W-2]) begin
          state_d = StRound;
        end else begin
          sig_d = sig_q << 1;
          exp_d = exp_q - EXP_W'(1);
        end
      end
      StRound: begin
        result_d = rnd_result;
        ovf_d    = rnd_ovf;
        unf_d    = rnd_unf;
        state_d  = StDone;
      end
      StDone: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers; reset abandons any transaction in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      sign_q   <= 1'b0;
      exp_q    <= '0;
      sig_q    <= '0;
      sticky_q <= 1'b0;
      zero_q   <= 1'b0;
      result_q <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      sign_q   <= sign_d;
      exp_q    <= exp_d;
      sig_q    <= sig_d;
      sticky_q <= sticky_d;
      zero_q   <= zero_d;
      result_q <= result_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  assign in_ready   = (state_q == StIdle) && !rst;
  assign out_valid  = (state_q == StDone);
  assign out_result = result_q;
  assign out_ovf    = ovf_q;
  assign out_unf    = unf_q;

endmodule

// File: doc/fp_norm_round.md
# fp_norm_round

Normalize-and-round stage that sits directly downstream of the 16-bit floating-point multiplier's raw significand product. It accepts an unnormalized sign / exponent / 24-bit product over a valid/ready handshake. It normalizes the product with a multi-cycle shift FSM, rounds it to the 11-bit fraction, and applies exponent range checks. It emits a packed 16-bit result (sign[15], biased exp[14:11], bias 7, frac[10:0], hidden leading 1) with overflow/underflow flags.

## Interface
- EXP_W, 7, width of the signed internal exponent
- SIG_W, 24, width of the raw significand product (two 12-bit 1.fff significands)
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  raw product valid
- in_ready  output  1  block can accept; high only in IDLE
- in_sign  input  1  product sign
- in_exp  input  EXP_W  signed biased exponent (e1+e2-7), range -7..23
- in_sig  input  SIG_W  raw product; binary point between bits 22 and 21
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- out_result  output  16  packed fp16 result
- out_ovf  output  1  exponent overflow; result saturated
- out_unf  output  1  exponent underflow or zero; result flushed

## Operation
- States: IDLE, NORM, ROUND, DONE.
- IDLE: in_ready=1. When in_valid is high, capture sign, exp and sig, then go to NORM.
- NORM evaluates one priority per cycle:
  - sig==0: zero flag set, go to ROUND.
  - sig[23]=1: sig>>=1 with the shifted-out bit ORed into sticky, exp+=1, go to ROUND.
  - sig[22]=1: go to ROUND.
  - Otherwise: sig<<=1, exp-=1, stay in NORM.
- ROUND:
  - frac=sig[21:11], guard=sig[10], sticky=|sig[9:0] OR the carried sticky bit.
  - Rounding is round-to-nearest-even (see Configuration).
  - If the fraction carries out of 11 bits: frac=0, exp+=1.
- Range check, applied after rounding:
  - zero flag set or exp<=0: result={sign,15'h0}, unf=1.
  - exp>15: result={sign,15'h7FFF}, ovf=1.
  - Otherwise: result={sign,exp[3:0],frac}.
  - Exp field 0 is reserved for zero. There are no infinities, NaNs or subnormals.
- DONE: out_valid=1. Result and flags are held stable until out_ready is high, then go to IDLE.
- Width rule: all exponent arithmetic is EXP_W-bit signed. The worst case is 22 left shifts from -7, giving -29, with no wrap.

## Timing
- Reset values: out_valid=0, out_result=16'h0000, out_ovf=0, out_unf=0, state=IDLE. in_ready is 0 while rst is high and 1 on the first cycle after.
- Reset mid-operation: the transaction is abandoned with no output produced.
- Latency, counted as out_valid rising this many edges after the accept edge:
  - 3 for in_sig[23:22]!=0 or in_sig==0.
  - +1 per left shift.
- No overlap: in_ready stays 0 from the accept edge until the cycle after the DONE handshake. Throughput is at most 1 result per 4 cycles.
- Inputs are sampled only on the accept edge; later changes are ignored.
- A held out_ready=0 stalls the block in DONE indefinitely with outputs constant.

## Configuration
- FP_NORM_RNE_EN:
  - Defined: round-to-nearest-even. Increment when guard & (sticky | frac[0]).
  - Undefined: truncation. The guard and sticky bits are ignored, and the round-overflow path is unreachable.

## Structure
- Shared package fp16_pkg holds:
  - FP_EXP_W=4, FP_FRAC_W=11, FP_BIAS=7, FP_EXP_MAX=15
  - the fp16 packed typedef (sign/exp/frac)
  - the state enum (IDLE, NORM, ROUND, DONE)
- Sub-module fp_round (combinational): inputs are sign, exp, frac, guard, sticky and the zero flag. Outputs are the packed result, ovf and unf. It contains the rounding, carry renormalization and range check. The macro is evaluated only here.

## Test plan
- 1.0×1.0: in_exp=7, in_sig=24'h400000 -> out_result=16'h3800, flags 0, latency 3.
- 1.5×1.5: in_exp=7, in_sig=24'h900000 -> 16'h4100 (right shift, exp 8), latency 3.
- Tie case: in_exp=7, in_sig=24'h400C00 -> 16'h3802 with FP_NORM_RNE_EN, 16'h3801 without.
- Round carry: in_exp=7, in_sig=24'h7FFC00 with RNE -> 16'h4000. Left shift: in_exp=9, in_sig=24'h100000 -> 16'h3800, latency 5.
- Range: in_exp=16, in_sig=24'h400000 -> 16'h7FFF with ovf=1. in_sign=1, in_exp=0 -> 16'h8000 with unf=1. in_sig=0 -> {sign,15'h0} with unf=1.
- Control: out_ready=0 for 10 cycles -> result held and in_ready=0. rst asserted in NORM -> out_valid=0 and IDLE on the next edge, with no stale result emitted afterwards.
